// File: rtl/score_arbiter_ctrl.sv
// Quiz-game score arbiter: synchronises player buttons, grants the first press per round,
// keeps saturating scores with thermometer LED bars, declares a winner and times a beep.
module score_arbiter_ctrl #(
  parameter int N_PLAYERS   = 2,
  parameter int SCORE_W     = 4,
  parameter int MAX_SCORE   = 5,
  parameter int LED_W       = 5,
  parameter int PENALTY_EN  = 1,
  parameter int BEEP_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PLAYERS-1:0]         btn,
  input  logic                         answer_ok,
  input  logic                         round_next,
  input  logic                         game_clr,
  output logic [N_PLAYERS*SCORE_W-1:0] score,
  output logic [N_PLAYERS*LED_W-1:0]   led_bar,
  output logic                         grant_valid,
  output logic [2:0]                   grant_id,
  output logic                         winner_valid,
  output logic [2:0]                   winner_id,
  output logic                         beep
);

  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {ST_ARMED, ST_LOCKED, ST_WON} state_t;

  function automatic logic [LED_W-1:0] therm(input logic [SCORE_W-1:0] s);
    logic [LED_W-1:0] t;
    t = '0;
    for (int j = 0; j < LED_W; j++) t[j] = (int'(s) > j);
    return t;
  endfunction

  logic [N_PLAYERS-1:0]       sync1_q, sync2_q, prev_q;
  logic [N_PLAYERS-1:0]       press;
  state_t                     state_q, state_d;
  logic [SCORE_W-1:0]         score_q [N_PLAYERS];
  logic [SCORE_W-1:0]         score_d [N_PLAYERS];
  logic [N_PLAYERS*LED_W-1:0] led_q, led_d;
  logic                       gv_q, gv_d, wv_q, wv_d;
  logic [2:0]                 gid_q, gid_d, wid_q, wid_d;
  logic [BEEP_W-1:0]          beep_cnt_q, beep_cnt_d;
  logic                       sel_found;
  int                         sel_idx;
  logic [SCORE_W-1:0]         inc_v;

  assign press = sync2_q & ~prev_q;

  always_comb begin
    state_d    = state_q;
    gv_d       = gv_q;
    gid_d      = gid_q;
    wv_d       = wv_q;
    wid_d      = wid_q;
    beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - 1'b1 : '0;
    inc_v      = '0;
    sel_found  = 1'b0;
    sel_idx    = 0;
    for (int i = 0; i < N_PLAYERS; i++) score_d[i] = score_q[i];
    // Fixed priority: the lowest-index press wins a simultaneous tie.
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (press[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = i;
      end
    end

    if (game_clr) begin
      for (int i = 0; i < N_PLAYERS; i++) score_d[i] = '0;
      gv_d       = 1'b0;
      wv_d       = 1'b0;
      beep_cnt_d = '0;
      state_d    = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sel_found) begin
            gv_d       = 1'b1;
            gid_d      = 3'(sel_idx);
            beep_cnt_d = BEEP_W'(BEEP_CYCLES);
            state_d    = ST_LOCKED;
            for (int i = 0; i < N_PLAYERS; i++) begin
              if (i == sel_idx) begin
                if (answer_ok) begin
                  inc_v      = (score_q[i] < MAX_S) ? score_q[i] + 1'b1 : MAX_S;
                  score_d[i] = inc_v;
                  if (inc_v == MAX_S) begin
                    wv_d    = 1'b1;
                    wid_d   = 3'(sel_idx);
                    state_d = ST_WON;
                  end
                end else if (PENALTY_EN != 0 && score_q[i] != '0) begin
                  score_d[i] = score_q[i] - 1'b1;
                end
              end
            end
          end
        end
        ST_LOCKED: begin
          if (round_next) begin
            state_d = ST_ARMED;
            gv_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    score = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      led_d[i*LED_W +: LED_W]   = therm(score_q[i]);
      score[i*SCORE_W +: SCORE_W] = score_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= ST_ARMED;
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
      led_q      <= '0;
      gv_q       <= 1'b0;
      gid_q      <= '0;
      wv_q       <= 1'b0;
      wid_q      <= '0;
      beep_cnt_q <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= score_d[i];
      led_q      <= led_d;
      gv_q       <= gv_d;
      gid_q      <= gid_d;
      wv_q       <= wv_d;
      wid_q      <= wid_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign led_bar      = led_q;
  assign grant_valid  = gv_q;
  assign grant_id     = gid_q;
  assign winner_valid = wv_q;
  assign winner_id    = wid_q;
  assign beep         = (beep_cnt_q != '0);

endmodule

// File: tb/tb_score_arbiter_ctrl.sv
// Bench for score_arbiter_ctrl: directed vector table, corner-case sequences and
// randomized traffic against a history-based behavioural model.
module tb_score_arbiter_ctrl;
  localparam int N = 2, SW = 4, MAXS = 5, LW = 5, PEN = 1, BC = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic answer_ok = 1'b0, round_next = 1'b0, game_clr = 1'b0;
  logic [N*SW-1:0] score;
  logic [N*LW-1:0] led_bar;
  logic grant_valid, winner_valid, beep;
  logic [2:0] grant_id, winner_id;

  always #5 clk = ~clk;

  score_arbiter_ctrl #(.N_PLAYERS(N), .SCORE_W(SW), .MAX_SCORE(MAXS), .LED_W(LW),
                       .PENALTY_EN(PEN), .BEEP_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .answer_ok(answer_ok), .round_next(round_next),
    .game_clr(game_clr), .score(score), .led_bar(led_bar), .grant_valid(grant_valid),
    .grant_id(grant_id), .winner_valid(winner_valid), .winner_id(winner_id), .beep(beep));

  int vectors = 0, miscompares = 0;

  // Reference model: button history per edge, scores as plain integers.
  int m_score [N];
  int m_src [N];
  int m_mode = 0;  // 0 armed, 1 locked, 2 won
  bit m_gv = 0, m_wv = 0;
  int m_gid = 0, m_wid = 0, m_beep = 0;
  logic [N-1:0] h1 = '0, h2 = '0, h3 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_score[i] = 0; m_src[i] = 0; end
      m_mode = 0; m_gv = 0; m_wv = 0; m_gid = 0; m_wid = 0; m_beep = 0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      automatic logic [N-1:0] pr = h2 & ~h3;
      automatic int p = -1;
      for (int i = 0; i < N; i++) m_src[i] = m_score[i];
      h3 = h2; h2 = h1; h1 = btn;
      for (int i = 0; i < N; i++) if (pr[i] && p < 0) p = i;
      if (m_beep > 0) m_beep--;
      if (game_clr) begin
        for (int i = 0; i < N; i++) m_score[i] = 0;
        m_gv = 0; m_wv = 0; m_beep = 0; m_mode = 0;
      end else if (m_mode == 0 && p >= 0) begin
        m_gv = 1; m_gid = p; m_beep = BC; m_mode = 1;
        if (answer_ok) begin
          if (m_score[p] < MAXS) m_score[p]++;
          if (m_score[p] == MAXS) begin m_wv = 1; m_wid = p; m_mode = 2; end
        end else if (PEN != 0 && m_score[p] > 0) begin
          m_score[p]--;
        end
      end else if (m_mode == 1 && round_next) begin
        m_mode = 0; m_gv = 0;
      end
    end
  end

  function automatic logic [N*SW-1:0] exp_score();
    logic [N*SW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(m_score[i]);
    return v;
  endfunction

  function automatic logic [N*LW-1:0] exp_led();
    logic [N*LW-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int t = (m_src[i] < LW) ? m_src[i] : LW;
      v[i*LW +: LW] = LW'((1 << t) - 1);
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".score"}, 32'(score), 32'(exp_score()));
    chk({tag, ".led"}, 32'(led_bar), 32'(exp_led()));
    chk({tag, ".gv"}, 32'(grant_valid), 32'(m_gv));
    chk({tag, ".gid"}, 32'(grant_id), 32'(m_gid));
    chk({tag, ".wv"}, 32'(winner_valid), 32'(m_wv));
    chk({tag, ".wid"}, 32'(winner_id), 32'(m_wid));
    chk({tag, ".beep"}, 32'(beep), 32'(m_beep != 0));
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; answer_ok = 1'b0; round_next = 1'b0; game_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic grant_btn(input int p, input logic ok);
    btn = N'(1 << p); answer_ok = ok;
    tick(); tick(); tick();
    btn = '0; answer_ok = 1'b0;
  endtask

  task automatic next_round();
    tick(); round_next = 1'b1; tick(); round_next = 1'b0; tick();
  endtask

  typedef struct {
    logic [1:0] b; logic ok, rn, clr;
    logic [7:0] sc; logic [9:0] led; logic gv; logic [2:0] gid; logic bp;
  } vec_t;
  vec_t tbl [16];

  function automatic vec_t mk(input logic [1:0] b, input logic ok, input logic rn,
                              input logic [7:0] sc, input logic [9:0] led,
                              input logic gv, input logic [2:0] gid, input logic bp);
    vec_t v;
    v.b = b; v.ok = ok; v.rn = rn; v.clr = 1'b0;
    v.sc = sc; v.led = led; v.gv = gv; v.gid = gid; v.bp = bp;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(2'b10, 1, 0, 8'h00, 10'h000, 0, 0, 0);
    tbl[1]  = mk(2'b10, 1, 0, 8'h00, 10'h000, 0, 0, 0);
    tbl[2]  = mk(2'b10, 1, 0, 8'h10, 10'h000, 1, 1, 1);
    tbl[3]  = mk(2'b00, 0, 0, 8'h10, 10'h020, 1, 1, 1);
    tbl[4]  = mk(2'b00, 0, 1, 8'h10, 10'h020, 0, 1, 1);
    tbl[5]  = mk(2'b11, 1, 0, 8'h10, 10'h020, 0, 1, 1);
    tbl[6]  = mk(2'b11, 1, 0, 8'h10, 10'h020, 0, 1, 1);
    tbl[7]  = mk(2'b11, 1, 0, 8'h11, 10'h020, 1, 0, 1);
    tbl[8]  = mk(2'b11, 1, 1, 8'h11, 10'h021, 0, 0, 1);
    tbl[9]  = mk(2'b11, 1, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[10] = mk(2'b11, 1, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[11] = mk(2'b00, 0, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[12] = mk(2'b00, 0, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[13] = mk(2'b01, 0, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[14] = mk(2'b01, 0, 0, 8'h11, 10'h021, 0, 0, 1);
    tbl[15] = mk(2'b01, 0, 0, 8'h10, 10'h021, 1, 0, 1);

    // Reset state
    tick(); tick();
    chk("rst.score", 32'(score), 0);
    chk("rst.led", 32'(led_bar), 0);
    chk("rst.gv", 32'(grant_valid), 0);
    chk("rst.wv", 32'(winner_valid), 0);
    chk("rst.beep", 32'(beep), 0);
    rst_n = 1'b1;

    // Directed table: first press, tie-break, held button, penalty
    for (int j = 0; j < 16; j++) begin
      btn = tbl[j].b; answer_ok = tbl[j].ok; round_next = tbl[j].rn; game_clr = tbl[j].clr;
      tick();
      chk($sformatf("v%0d.score", j), 32'(score), 32'(tbl[j].sc));
      chk($sformatf("v%0d.led", j), 32'(led_bar), 32'(tbl[j].led));
      chk($sformatf("v%0d.gv", j), 32'(grant_valid), 32'(tbl[j].gv));
      chk($sformatf("v%0d.gid", j), 32'(grant_id), 32'(tbl[j].gid));
      chk($sformatf("v%0d.beep", j), 32'(beep), 32'(tbl[j].bp));
    end
    btn = '0; answer_ok = 1'b0; round_next = 1'b0;

    // Penalty from 3 down to 2
    do_reset();
    for (int k = 0; k < 3; k++) begin grant_btn(0, 1'b1); next_round(); end
    grant_btn(0, 1'b0);
    chk("pen3.score", 32'(score), 32'h02);
    next_round();

    // Win at MAX_SCORE, then presses and round_next are ignored
    do_reset();
    for (int k = 0; k < 5; k++) begin
      grant_btn(1, 1'b1);
      chk($sformatf("win%0d.score", k), 32'(score), 32'((k + 1) << 4));
      if (k < 4) next_round();
    end
    chk("win.wv", 32'(winner_valid), 1);
    chk("win.wid", 32'(winner_id), 1);
    next_round();
    chk("win.led", 32'(led_bar), 32'h3E0);
    grant_btn(0, 1'b1);
    next_round();
    chk("won.score", 32'(score), 32'h50);
    chk("won.gid", 32'(grant_id), 1);
    chk("won.wv", 32'(winner_valid), 1);
    check_model("won");

    // game_clr on the press edge loses the press
    btn = 2'b01; answer_ok = 1'b1;
    tick(); tick();
    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    chk("clr.score", 32'(score), 0);
    chk("clr.gv", 32'(grant_valid), 0);
    chk("clr.wv", 32'(winner_valid), 0);
    chk("clr.beep", 32'(beep), 0);
    tick();
    chk("clr.lost", 32'(grant_valid), 0);
    btn = '0; tick(); tick();
    grant_btn(0, 1'b1);
    chk("clr.next.score", 32'(score), 32'h01);
    chk("clr.next.gid", 32'(grant_id), 0);
    chk("clr.next.gv", 32'(grant_valid), 1);
    check_model("clr");

    // Asynchronous reset mid-beep while locked
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.score", 32'(score), 0);
    chk("arst.led", 32'(led_bar), 0);
    chk("arst.gv", 32'(grant_valid), 0);
    chk("arst.gid", 32'(grant_id), 0);
    chk("arst.beep", 32'(beep), 0);
    @(negedge clk);
    rst_n = 1'b1;
    grant_btn(1, 1'b1);
    chk("arst.next.score", 32'(score), 32'h10);
    chk("arst.next.gv", 32'(grant_valid), 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("beep.on%0d", k), 32'(beep), 1);
    end
    tick();
    chk("beep.off", 32'(beep), 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) btn[i] = ~btn[i];
      answer_ok  = ($urandom_range(3) != 0);
      round_next = ($urandom_range(5) == 0);
      game_clr   = ($urandom_range(59) == 0);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
